// File: rtl/stepper_pkg.sv
// Shared definitions for the PmodSTEP sequencer: modes, FSM states and coil phase table.
package stepper_pkg;

    localparam logic [1:0] MODE_WAVE = 2'b00;
    localparam logic [1:0] MODE_FULL = 2'b01;
    localparam logic [1:0] MODE_HALF = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    typedef enum logic {IDLE, RUN} state_e;

    // Coil order A B A' B'; entry 0 is the rightmost element.
    localparam logic [7:0][3:0] PHASE_TABLE = {
        4'b1001, 4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001
    };

    // Wave lives on even indices, full on odd; a mis-parity ptr moves one slot to realign.
    function automatic logic [2:0] next_ptr(input logic [2:0] ptr, input logic dir,
                                            input logic [1:0] mode);
        logic [2:0] delta;
        if (mode == MODE_HALF) begin
            delta = 3'd1;
        end else if (mode == MODE_WAVE) begin
            delta = ptr[0] ? 3'd1 : 3'd2;
        end else begin
            delta = ptr[0] ? 3'd2 : 3'd1;
        end
        return dir ? ptr + delta : ptr - delta;
    endfunction

endpackage

// File: rtl/stepper_seq_driver_if.sv
// Command/status bundle between a motion controller (master) and the stepper driver (slave).
interface stepper_seq_driver_if #(
    parameter int unsigned DIV_W  = 20,
    parameter int unsigned STEP_W = 16
);
    logic              start;
    logic [STEP_W-1:0] steps;
    logic              direction;
    logic [1:0]        mode;
    logic [DIV_W-1:0]  period;
    logic              abort;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [STEP_W-1:0] steps_left;
    logic [3:0]        signal;

    modport master (
        output start, steps, direction, mode, period, abort,
        input  busy, done, aborted, steps_left, signal
    );

    modport slave (
        input  start, steps, direction, mode, period, abort,
        output busy, done, aborted, steps_left, signal
    );
endinterface

// File: rtl/step_rate_div.sv
// Loadable down-counter; tick is high during the last cycle of each loaded interval.
module step_rate_div #(
    parameter int unsigned DIV_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    output logic             tick
);

    logic [DIV_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - DIV_W'(1);
        end
    end

    assign tick = (count_q == DIV_W'(1));

endmodule

// File: rtl/stepper_seq_driver.sv
// PmodSTEP sequencer: executes N-step moves in wave/full/half mode with start/busy/done/abort.
// Define STEPPER_HOLD_TORQUE_EN to keep the last phase energised while idle.
module stepper_seq_driver
    import stepper_pkg::*;
#(
    parameter int unsigned DIV_W  = 20,
    parameter int unsigned STEP_W = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    stepper_seq_driver_if.slave bus
);

    state_e            state_q, state_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [STEP_W-1:0] steps_left_q, steps_left_d;
    logic [3:0]        signal_q, signal_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic              dir_q, dir_d;
    logic [1:0]        mode_q, mode_d;
    logic [DIV_W-1:0]  period_q, period_d;

    logic              div_load;
    logic [DIV_W-1:0]  div_val;
    logic              div_tick;
    logic [1:0]        norm_mode;
    logic [DIV_W-1:0]  norm_period;
    logic [3:0]        idle_signal;

    assign norm_mode   = (bus.mode == MODE_RSVD) ? MODE_FULL : bus.mode;
    assign norm_period = (bus.period == '0) ? DIV_W'(1) : bus.period;

`ifdef STEPPER_HOLD_TORQUE_EN
    assign idle_signal = signal_q;
`else
    assign idle_signal = 4'b0000;
`endif

    step_rate_div #(
        .DIV_W(DIV_W)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (div_load),
        .load_val(div_val),
        .tick    (div_tick)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        steps_left_d = steps_left_q;
        signal_d     = signal_q;
        done_d       = 1'b0;
        aborted_d    = aborted_q;
        dir_d        = dir_q;
        mode_d       = mode_q;
        period_d     = period_q;
        div_load     = 1'b0;
        div_val      = period_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    aborted_d = 1'b0;
                    if (bus.steps == '0) begin
                        steps_left_d = '0;
                        done_d       = 1'b1;
                    end else begin
                        dir_d        = bus.direction;
                        mode_d       = norm_mode;
                        period_d     = norm_period;
                        ptr_d        = next_ptr(ptr_q, bus.direction, norm_mode);
                        signal_d     = PHASE_TABLE[ptr_d];
                        steps_left_d = bus.steps - STEP_W'(1);
                        div_load     = 1'b1;
                        div_val      = norm_period;
                        state_d      = RUN;
                    end
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                    signal_d  = idle_signal;
                end else if (div_tick) begin
                    if (steps_left_q != '0) begin
                        ptr_d        = next_ptr(ptr_q, dir_q, mode_q);
                        signal_d     = PHASE_TABLE[ptr_d];
                        steps_left_d = steps_left_q - STEP_W'(1);
                        div_load     = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        done_d   = 1'b1;
                        signal_d = idle_signal;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= 3'd0;
            steps_left_q <= '0;
            signal_q     <= 4'b0000;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            dir_q        <= 1'b0;
            mode_q       <= MODE_WAVE;
            period_q     <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            steps_left_q <= steps_left_d;
            signal_q     <= signal_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            dir_q        <= dir_d;
            mode_q       <= mode_d;
            period_q     <= period_d;
        end
    end

    assign bus.busy       = (state_q == RUN);
    assign bus.done       = done_q;
    assign bus.aborted    = aborted_q;
    assign bus.steps_left = steps_left_q;
    assign bus.signal     = signal_q;

endmodule

// File: tb/tb_stepper_seq_driver.sv
// Scoreboard bench: expected coil phases and hold lengths are queued per move and
// popped as the DUT produces each phase run.
module tb_stepper_seq_driver;

    localparam int unsigned DIV_W  = 20;
    localparam int unsigned STEP_W = 16;

    typedef struct {
        logic [3:0] sig;
        int         len;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    int   ptr_m;
    exp_t exp_q[$];
    logic [3:0] phase_tbl [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                  4'b0100, 4'b1100, 4'b1000, 4'b1001};

    stepper_seq_driver_if #(.DIV_W(DIV_W), .STEP_W(STEP_W)) bus_if ();

    stepper_seq_driver #(
        .DIV_W (DIV_W),
        .STEP_W(STEP_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int m_next(input int p, input bit dir, input int md);
        int d;
        if (md == 2) d = 1;
        else if (md == 0) d = (p % 2 == 0) ? 2 : 1;
        else d = (p % 2 == 1) ? 2 : 1;
        return dir ? (p + d) % 8 : (p + 8 - d) % 8;
    endfunction

    function automatic logic [3:0] idle_sig();
`ifdef STEPPER_HOLD_TORQUE_EN
        return phase_tbl[ptr_m];
`else
        return 4'b0000;
`endif
    endfunction

    task automatic close_run(input logic [3:0] sig, input int len);
        exp_t e;
        check_eq("phase_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("phase_sig", sig, e.sig);
            check_eq("phase_len", len, e.len);
        end
    endtask

    // abort_cyc: busy cycle (1-based) with abort high; stray_cyc: busy cycle with a stray start.
    task automatic run_move(input int n, input bit dir, input logic [1:0] md, input int per,
                            input int abort_cyc, input int stray_cyc);
        int em, ep, shown, last_len, busy_exp, cyc, cur_len;
        logic [3:0] cur_sig;
        bit ended;
        exp_t e;
        em = (md == 2'b11) ? 1 : int'(md);
        ep = (per == 0) ? 1 : per;
        if (abort_cyc > 0) begin
            shown    = (abort_cyc + ep - 1) / ep;
            last_len = abort_cyc - (shown - 1) * ep;
            busy_exp = abort_cyc;
        end else begin
            shown    = n;
            last_len = ep;
            busy_exp = n * ep;
        end
        for (int i = 0; i < shown; i++) begin
            ptr_m = m_next(ptr_m, dir, em);
            e.sig = phase_tbl[ptr_m];
            e.len = (i == shown - 1) ? last_len : ep;
            exp_q.push_back(e);
        end

        bus_if.steps     = STEP_W'(n);
        bus_if.direction = dir;
        bus_if.mode      = md;
        bus_if.period    = DIV_W'(per);
        bus_if.start     = 1'b1;
        cyc = 0;
        cur_len = 0;
        cur_sig = 4'b0000;
        ended = 1'b0;
        for (int t = 0; t < 4000 && !ended; t++) begin
            @(posedge clk);
            #1;
            bus_if.start = 1'b0;
            bus_if.abort = 1'b0;
            if (bus_if.busy) begin
                cyc++;
                if (cyc == 1) check_eq("steps_left_first", bus_if.steps_left, n - 1);
                if (cur_len == 0) begin
                    cur_sig = bus_if.signal;
                    cur_len = 1;
                end else if (bus_if.signal !== cur_sig) begin
                    close_run(cur_sig, cur_len);
                    cur_sig = bus_if.signal;
                    cur_len = 1;
                end else begin
                    cur_len++;
                end
                if (cyc == abort_cyc) bus_if.abort = 1'b1;
                if (cyc == stray_cyc) begin
                    bus_if.start     = 1'b1;
                    bus_if.steps     = STEP_W'(1);
                    bus_if.mode      = 2'b10;
                    bus_if.direction = ~dir;
                end
            end else begin
                ended = 1'b1;
            end
        end
        check_eq("move_ended", ended, 1);
        if (cur_len > 0) close_run(cur_sig, cur_len);
        check_eq("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        check_eq("busy_cycles", cyc, busy_exp);
        check_eq("done_pulse", bus_if.done, 1);
        check_eq("aborted_flag", bus_if.aborted, (abort_cyc > 0));
        check_eq("steps_left_end", bus_if.steps_left, n - shown);
        check_eq("idle_signal", bus_if.signal, idle_sig());
        @(posedge clk);
        #1;
        check_eq("done_one_cycle", bus_if.done, 0);
    endtask

    initial begin
        logic [3:0] sig_before;
        n_checks = 0;
        n_pass = 0;
        ptr_m = 0;
        rst_n = 1'b0;
        bus_if.start = 1'b0;
        bus_if.steps = '0;
        bus_if.direction = 1'b0;
        bus_if.mode = 2'b00;
        bus_if.period = '0;
        bus_if.abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", bus_if.busy, 0);
        check_eq("rst_done", bus_if.done, 0);
        check_eq("rst_aborted", bus_if.aborted, 0);
        check_eq("rst_steps_left", bus_if.steps_left, 0);
        check_eq("rst_signal", bus_if.signal, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_move(4, 1'b1, 2'b10, 3, 0, 0);  // half: 0011 0010 0110 0100
        run_move(5, 1'b1, 2'b00, 2, 0, 0);  // wave from 4: 1000 0001 0010 0100 1000

        // Asynchronous reset mid-move.
        bus_if.steps = STEP_W'(8);
        bus_if.direction = 1'b1;
        bus_if.mode = 2'b10;
        bus_if.period = DIV_W'(2);
        bus_if.start = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        check_eq("pre_reset_busy", bus_if.busy, 1);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_reset_signal", bus_if.signal, 0);
        check_eq("mid_reset_busy", bus_if.busy, 0);
        check_eq("mid_reset_steps_left", bus_if.steps_left, 0);
        ptr_m = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_move(3, 1'b0, 2'b01, 2, 0, 0);  // full from 0: 1001 1100 0110
        run_move(2, 1'b0, 2'b00, 1, 0, 0);  // wave from odd 3: 0010 0001
        run_move(10, 1'b1, 2'b10, 2, 5, 0); // abort in step 3 -> steps_left 7

        // Zero-length move clears aborted and leaves the coils alone.
        sig_before = bus_if.signal;
        bus_if.steps = '0;
        bus_if.start = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        check_eq("zero_busy", bus_if.busy, 0);
        check_eq("zero_done", bus_if.done, 1);
        check_eq("zero_aborted_clr", bus_if.aborted, 0);
        check_eq("zero_signal", bus_if.signal, sig_before);
        @(posedge clk);
        #1;
        check_eq("zero_done_clr", bus_if.done, 0);

        // Reserved mode behaves as full, period 0 as 1, stray start ignored.
        run_move(3, 1'b1, 2'b11, 0, 0, 2);

        // Abort in idle and start+abort together do nothing.
        sig_before = bus_if.signal;
        bus_if.abort = 1'b1;
        @(posedge clk);
        #1;
        check_eq("idle_abort_done", bus_if.done, 0);
        check_eq("idle_abort_signal", bus_if.signal, sig_before);
        bus_if.steps = STEP_W'(5);
        bus_if.start = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        bus_if.abort = 1'b0;
        check_eq("start_abort_busy", bus_if.busy, 0);
        check_eq("start_abort_done", bus_if.done, 0);
        @(posedge clk);
        #1;
        check_eq("start_abort_busy2", bus_if.busy, 0);

        run_move(2, 1'b0, 2'b10, 1, 0, 0);  // confirms position survived the idle noise

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
